// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning architectural HI/LO.
// Latency: mult/multu/madd* MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo commit at the start edge.
// Backpressure: stall_req holds D while an MD-class instr waits on an in-flight or starting mult/div.
//
// Ports:
//   clk, reset     clock; synchronous active-low reset
//   md_start       valid MD op in E this cycle
//   md_op[2:0]     000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu
//   src_a, src_b   forwarded rs / rt operands
//   d_md_use       D stage holds an MD-class instruction
//   hi_out, lo_out architectural HI / LO
//   busy           registered, high while a mult/div is in flight
//   stall_req      combinational stall request to D
//
// Optional feature: define MDU_MADD_EN to enable madd/maddu (ops 110/111);
// otherwise those ops are no-ops.

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall_req
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_we_q, pend_we_d;   // cleared for divide-by-zero so HI/LO survive

  // Op decode; even opcodes of the arithmetic classes are the signed variants.
  logic is_mul, is_div, is_mthi, is_mtlo, is_madd, is_long, signed_op;
  assign is_mul    = (md_op[2:1] == 2'b00);
  assign is_div    = (md_op[2:1] == 2'b01);
  assign is_mthi   = (md_op == 3'b100);
  assign is_mtlo   = (md_op == 3'b101);
`ifdef MDU_MADD_EN
  assign is_madd   = (md_op[2:1] == 2'b11);
`else
  assign is_madd   = 1'b0;
`endif
  assign is_long   = is_mul | is_div | is_madd;
  assign signed_op = ~md_op[0];

  // Multiply: sign/zero-extend to 64 bits; the low 64 bits of the product are
  // correct for both signed and unsigned interpretation.
  logic [63:0] a_ext, b_ext, product;
  assign a_ext   = signed_op ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
  assign b_ext   = signed_op ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
  assign product = a_ext * b_ext;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q} + product;
`endif

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 with no special case.
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, dvsr, q_mag, r_mag, quot, rem;
  assign a_neg    = signed_op & src_a[31];
  assign b_neg    = signed_op & src_b[31];
  assign a_mag    = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag    = b_neg ? (~src_b + 32'd1) : src_b;
  assign div_zero = (src_b == 32'd0);
  assign dvsr     = div_zero ? 32'd1 : b_mag;  // keeps the divider defined; result discarded
  assign q_mag    = a_mag / dvsr;
  assign r_mag    = a_mag % dvsr;
  assign quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (state_q == IDLE) begin
      if (md_start) begin
        if (is_mul || is_madd) begin
`ifdef MDU_MADD_EN
          {pend_hi_d, pend_lo_d} = is_madd ? acc : product;
`else
          {pend_hi_d, pend_lo_d} = product;
`endif
          pend_we_d = 1'b1;
          cnt_d     = MULT_N;
          state_d   = RUN;
        end else if (is_div) begin
          pend_hi_d = rem;
          pend_lo_d = quot;
          pend_we_d = ~div_zero;
          cnt_d     = DIV_N;
          state_d   = RUN;
        end else if (is_mthi) begin
          hi_d = src_a;
        end else if (is_mtlo) begin
          lo_d = src_a;
        end
      end
    end else begin
      // md_start is ignored here; D is stalled so it should never arrive.
      if (cnt_q == 4'd1) begin
        if (pend_we_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        cnt_d   = 4'd0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && (state_q == RUN) && md_start)
      $display("e_mdu: warning: md_start while busy ignored (op %b)", md_op);
  end
`endif

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign busy      = (state_q == RUN);
  assign stall_req = reset & d_md_use & (busy | (md_start & is_long));

endmodule
